ccff_loader: RTL and testbench
==============================

CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 22: number of configuration-chain flip-flops driven by this loader; legal values are 1 and above.
REQ-002 Parameter WORD_W, default 8: bitstream word width; legal values are 1 and above.
REQ-003 Port prog_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port pReset, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: begins a load; sampled only in IDLE.
REQ-006 Port check_en, input, 1: sampled with start; selects load-and-verify (two passes).
REQ-007 Port s_data, input, WORD_W: bitstream word; bit 0 is shifted first.
REQ-008 Port s_valid, input, 1: s_data is valid.
REQ-009 Port s_ready, output, 1: loader accepts a word this cycle.
REQ-010 Port ccff_head, output, 1: serial bit into the chain head.
REQ-011 Port ccff_tail, input, 1: chain tail return, used for verify.
REQ-012 Port prog_en, output, 1: chain clock enable; the external clock gate shifts the chain on the prog_clk edge that ends a cycle with prog_en=1.
REQ-013 Port busy, output, 1: a load is in progress.
REQ-014 Port done, output, 1: one-cycle pulse when a load completes.
REQ-015 Port error, output, 1: sticky verify mismatch; cleared by the next accepted start.

Function
REQ-016 States SHALL be: IDLE, FETCH, SHIFT, DONE.
REQ-017 IDLE: when start=1, SHALL latch check_en, clear error, clear the bit counter, set pass=1, and go to FETCH; otherwise stay in IDLE.
REQ-018 FETCH: s_ready=1; on s_valid=1, SHALL load s_data into a shift register, clear the word-bit index, and go to SHIFT; otherwise stay in FETCH with no shifting.
REQ-019 SHIFT, every cycle: prog_en=1, ccff_head=sreg[0], sreg shifts right by 1, bit counter and word-bit index each increment by 1.
REQ-020 SHIFT exit, when the bit counter reaches CHAIN_LEN-1:
  - check mode with pass=1: go to FETCH with pass=2 and the bit counter cleared.
  - otherwise: go to DONE.
  - unshifted bits of the current word are discarded.
REQ-021 SHIFT exit, else when the word-bit index reaches WORD_W-1: go to FETCH.
REQ-022 Outside SHIFT: prog_en=0 and ccff_head=0.
REQ-023 s_ready SHALL be 1 only in FETCH.
REQ-024 Each pass SHALL produce exactly CHAIN_LEN prog_en cycles and consume ceil(CHAIN_LEN/WORD_W) words.
REQ-025 Verify: in pass 2, for every SHIFT cycle where ccff_tail != sreg[0], error SHALL be set on that edge. The host resends the identical bitstream, so ccff_tail carries pass-1 bit k at pass-2 shift k.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE; error holds its value.
REQ-027 busy SHALL be 1 in FETCH, SHIFT and DONE, and 0 in IDLE.
REQ-028 start outside IDLE SHALL be ignored, with no state, counter or error change.
REQ-029 Throughput SHALL be at most WORD_W+1 cycles per word; s_valid gaps only insert FETCH cycles.
REQ-030 Counter widths SHALL be clog2(CHAIN_LEN+1) bits (bit counter) and clog2(WORD_W+1) bits (word-bit index), with no wrap inside a pass.

Reset
REQ-031 While pReset=1, the following SHALL hold immediately, independent of prog_clk:
  - state=IDLE; sreg, counters, pass, check flag and error cleared.
  - busy, done, error, s_ready, prog_en and ccff_head all 0.
REQ-032 pReset mid-load SHALL abort the load; chain contents are undefined, and the next start begins a fresh load with no residue.

Verification
REQ-033 Basic load: CHAIN_LEN=22, WORD_W=8, check_en=0, words 0xA5, 0x3C, 0x15 ->
  - exactly 22 prog_en cycles.
  - ccff_head = 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,0,1,0,1,0.
  - 22-bit chain model holds the expected image.
  - one done pulse, error=0.
REQ-034 Same stream with 5-cycle s_valid gaps before each word -> identical head bit sequence; prog_en=0 and s_ready=1 during the gaps.
REQ-035 check_en=1, stream sent twice into a 22-FF chain model -> 44 prog_en cycles, done pulse, error=0.
REQ-036 check_en=1 into a 21-FF chain model (broken chain) -> error=1 at done and held until the next start.
REQ-037 pReset asserted for 1 cycle mid-SHIFT of word 2 -> busy, prog_en and s_ready go 0 without a clock edge; a following clean load reproduces the REQ-033 result.
REQ-038 start pulsed in FETCH and in SHIFT -> ignored; prog_en count and head sequence unchanged; exactly one done pulse.

Source files
------------

// File: rtl/ccff_loader.sv
// Serialises bitstream words onto a configuration flip-flop chain, LSB first, with an optional second verify pass.
// Throughput is one chain bit per cycle plus one fetch cycle per word; s_valid gaps stall in FETCH.
module ccff_loader #(
  parameter int CHAIN_LEN = 22,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              check_en,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              prog_en,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int IW = $clog2(WORD_W + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(CHAIN_LEN - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WORD_W - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

  state_t            state;
  logic [WORD_W-1:0] sreg;
  logic [BW-1:0]     bit_cnt;
  logic [IW-1:0]     idx;
  logic              pass2;
  logic              chk;

  // prog_en is only high in SHIFT, so this gates the head bit to 0 elsewhere
  assign ccff_head = prog_en & sreg[0];

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      idx     <= '0;
      pass2   <= 1'b0;
      chk     <= 1'b0;
      error   <= 1'b0;
      s_ready <= 1'b0;
      prog_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            chk     <= check_en;
            error   <= 1'b0;
            bit_cnt <= '0;
            pass2   <= 1'b0;
            state   <= FETCH;
            s_ready <= 1'b1;
            busy    <= 1'b1;
          end
        end
        FETCH: begin
          if (s_valid) begin
            sreg    <= s_data;
            idx     <= '0;
            state   <= SHIFT;
            s_ready <= 1'b0;
            prog_en <= 1'b1;
          end
        end
        SHIFT: begin
          sreg    <= sreg >> 1;
          bit_cnt <= bit_cnt + 1'b1;
          idx     <= idx + 1'b1;
          // In pass 2 the tail returns the pass-1 bit that lines up with the one leaving now
          if (pass2 && (ccff_tail != sreg[0]))
            error <= 1'b1;
          if (bit_cnt == BIT_LAST) begin
            prog_en <= 1'b0;
            if (chk && !pass2) begin
              pass2   <= 1'b1;
              bit_cnt <= '0;
              state   <= FETCH;
              s_ready <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else if (idx == IDX_LAST) begin
            prog_en <= 1'b0;
            state   <= FETCH;
            s_ready <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader: a chain model on the head/tail pins plus a queue of expected head bits.
module tb_ccff_loader;

  localparam int N = 22;
  localparam int W = 8;
  localparam logic [N-1:0] IMAGE = 22'h294F2A;

  logic         prog_clk = 1'b0;
  logic         pReset = 1'b1;
  logic         start = 1'b0;
  logic         check_en = 1'b0;
  logic [W-1:0] s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_ready, ccff_head, ccff_tail, prog_en, busy, done, error;

  logic [N-1:0] chain = '0;
  logic         short_chain = 1'b0;
  int           n_assert = 0;
  int           n_fail = 0;
  int           prog_cnt = 0;
  int           done_cnt = 0;
  bit           exp_q[$];
  logic [W-1:0] words [3] = '{8'hA5, 8'h3C, 8'h15};

  ccff_loader #(.CHAIN_LEN(N), .WORD_W(W)) dut (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .start    (start),
    .check_en (check_en),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .ccff_head(ccff_head),
    .ccff_tail(ccff_tail),
    .prog_en  (prog_en),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 prog_clk = ~prog_clk;

  // Chain model: head enters at bit 0; the short variant drops the last flop
  always @(posedge prog_clk) if (prog_en === 1'b1) chain <= {chain[N-2:0], ccff_head};
  assign ccff_tail = short_chain ? chain[N-2] : chain[N-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge prog_clk) begin
    if (prog_en === 1'b1) begin
      prog_cnt++;
      chk("head_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("head_bit", ccff_head, exp_q.pop_front());
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic send_word(input logic [W-1:0] w, input int gap, input int nbits, input bit poke);
    int t = 0;
    while (s_ready !== 1'b1 && t < 200) begin
      @(negedge prog_clk);
      t++;
    end
    chk("ready_wait", s_ready, 1);
    for (int i = 0; i < gap; i++) begin
      chk("gap_s_ready", s_ready, 1);
      chk("gap_prog_en", prog_en, 0);
      if (poke && i == 0) start = 1'b1;
      @(negedge prog_clk);
      start = 1'b0;
    end
    for (int b = 0; b < nbits; b++) exp_q.push_back(w[b]);
    s_valid = 1'b1;
    s_data  = w;
    @(negedge prog_clk);
    s_valid = 1'b0;
  endtask

  task automatic load(input bit chk_mode, input bit short_c, input int gap, input bit poke, input bit exp_err);
    int t = 0;
    prog_cnt    = 0;
    done_cnt    = 0;
    short_chain = short_c;
    @(negedge prog_clk);
    start    = 1'b1;
    check_en = chk_mode;
    @(negedge prog_clk);
    start    = 1'b0;
    check_en = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("error_cleared", error, 0);
    for (int p = 0; p < (chk_mode ? 2 : 1); p++) begin
      int rem = N;
      for (int w = 0; w < 3; w++) begin
        send_word(words[w], gap, (rem < W) ? rem : W, poke && p == 0 && w == 1);
        rem -= W;
        if (poke && p == 0 && w == 0) begin
          start    = 1'b1;
          check_en = 1'b1;
          @(negedge prog_clk);
          start    = 1'b0;
          check_en = 1'b0;
        end
      end
    end
    while (done !== 1'b1 && t < 300) begin
      @(negedge prog_clk);
      t++;
    end
    chk("done_seen", done, 1);
    chk("error_at_done", error, exp_err);
    repeat (3) @(negedge prog_clk);
    chk("prog_en_cycles", prog_cnt, chk_mode ? 44 : 22);
    chk("done_pulses", done_cnt, 1);
    chk("busy_idle", busy, 0);
    chk("queue_drained", exp_q.size(), 0);
    chk("error_held", error, exp_err);
    if (!short_c) chk("chain_image", chain, IMAGE);
  endtask

  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_prog_en", prog_en, 0);
    chk("rst_head", ccff_head, 0);
    repeat (2) @(negedge prog_clk);
    pReset = 1'b0;

    load(1'b0, 1'b0, 0, 1'b0, 1'b0);   // basic load
    load(1'b0, 1'b0, 5, 1'b0, 1'b0);   // 5-cycle gaps before each word
    load(1'b1, 1'b0, 0, 1'b0, 1'b0);   // load and verify, intact chain
    load(1'b1, 1'b1, 0, 1'b0, 1'b1);   // load and verify, broken chain

    // Abort in the middle of the second word
    prog_cnt = 0;
    @(negedge prog_clk);
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    chk("error_cleared_by_start", error, 0);
    send_word(words[0], 0, W, 1'b0);
    send_word(words[1], 0, W, 1'b0);
    repeat (3) @(negedge prog_clk);
    chk("mid_shift_prog_en", prog_en, 1);
    #1 pReset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_prog_en", prog_en, 0);
    chk("abort_s_ready", s_ready, 0);
    chk("abort_head", ccff_head, 0);
    @(negedge prog_clk);
    pReset = 1'b0;
    exp_q.delete();
    load(1'b0, 1'b0, 0, 1'b0, 1'b0);   // clean load after abort

    load(1'b0, 1'b0, 3, 1'b1, 1'b0);   // start poked in SHIFT and in FETCH

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
